// File: rtl/mem_stage.sv
// MIPS memory-access stage: branch resolve, req/ack data-memory FSM with timeout, MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_RegWrite,
    input  logic        MEM_Branch,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_zero,
    input  logic [31:0] MEM_ALU_res,
    input  logic [31:0] MEM_rdata2,
    input  logic [4:0]  MEM_wreg,
    output logic        MEM_PCSrc,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        WB_MemtoReg,
    output logic        WB_RegWrite,
    output logic [31:0] WB_ALU_res,
    output logic [31:0] WB_mdata,
    output logic [4:0]  WB_wreg,
    output logic        bus_err,
    output logic        misalign
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        mem_op, mis_addr, last_cnt;
    logic        ack_take, timeout_hit, mis_hit;

    logic        wb_memtoreg_q, wb_memtoreg_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic [31:0] wb_alu_res_q,  wb_alu_res_d;
    logic [31:0] wb_mdata_q,    wb_mdata_d;
    logic [4:0]  wb_wreg_q,     wb_wreg_d;
    logic        bus_err_q,     bus_err_d;
    logic        misalign_q,    misalign_d;

    assign mem_op = MEM_MemRead | MEM_MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_addr = mem_op & (MEM_ALU_res[1:0] != 2'b00);
`else
    assign mis_addr = 1'b0;
`endif

    assign last_cnt  = (cnt_q == CW'(TIMEOUT - 1));
    assign MEM_PCSrc = MEM_Branch & MEM_zero;
    assign dm_addr   = {MEM_ALU_res[31:2], 2'b00};
    assign dm_wdata  = MEM_rdata2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mem_op && !mis_addr) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (dm_ack || last_cnt) state_d = IDLE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus and stall are gated by rst_n so they fall the instant reset asserts.
    always_comb begin
        dm_req      = 1'b0;
        dm_we       = 1'b0;
        stall       = 1'b0;
        ack_take    = 1'b0;
        timeout_hit = 1'b0;
        mis_hit     = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    stall   = mem_op & ~mis_addr;
                    mis_hit = mis_addr;
                end
                ACCESS: begin
                    dm_req      = 1'b1;
                    dm_we       = MEM_MemWrite;
                    stall       = ~dm_ack & ~last_cnt;
                    ack_take    = dm_ack;
                    timeout_hit = ~dm_ack & last_cnt;
                end
                default: ;
            endcase
        end
    end

    // MEM/WB next value; priority keeps ack ahead of timeout in the same cycle.
    always_comb begin
        wb_memtoreg_d = wb_memtoreg_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_alu_res_d  = wb_alu_res_q;
        wb_mdata_d    = wb_mdata_q;
        wb_wreg_d     = wb_wreg_q;
        bus_err_d     = 1'b0;
        misalign_d    = 1'b0;
        if (stall) begin
            wb_memtoreg_d = 1'b0;
            wb_regwrite_d = 1'b0;
        end else if (ack_take) begin
            wb_memtoreg_d = MEM_MemtoReg;
            wb_regwrite_d = MEM_RegWrite;
            wb_alu_res_d  = MEM_ALU_res;
            wb_mdata_d    = dm_rdata;
            wb_wreg_d     = MEM_wreg;
        end else if (timeout_hit) begin
            wb_memtoreg_d = 1'b0;
            wb_regwrite_d = 1'b0;
            bus_err_d     = 1'b1;
        end else if (mis_hit) begin
            wb_memtoreg_d = 1'b0;
            wb_regwrite_d = 1'b0;
            misalign_d    = 1'b1;
        end else begin
            wb_memtoreg_d = MEM_MemtoReg;
            wb_regwrite_d = MEM_RegWrite;
            wb_alu_res_d  = MEM_ALU_res;
            wb_wreg_d     = MEM_wreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_memtoreg_q <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_alu_res_q  <= '0;
            wb_mdata_q    <= '0;
            wb_wreg_q     <= '0;
            bus_err_q     <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_alu_res_q  <= wb_alu_res_d;
            wb_mdata_q    <= wb_mdata_d;
            wb_wreg_q     <= wb_wreg_d;
            bus_err_q     <= bus_err_d;
            misalign_q    <= misalign_d;
        end
    end

    assign WB_MemtoReg = wb_memtoreg_q;
    assign WB_RegWrite = wb_regwrite_q;
    assign WB_ALU_res  = wb_alu_res_q;
    assign WB_mdata    = wb_mdata_q;
    assign WB_wreg     = wb_wreg_q;
    assign bus_err     = bus_err_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, branch, load/store handshake, timeout, reset abort, alignment.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_MemtoReg, MEM_RegWrite, MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_zero;
    logic [31:0] MEM_ALU_res, MEM_rdata2;
    logic [4:0]  MEM_wreg;
    logic        MEM_PCSrc, stall, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        WB_MemtoReg, WB_RegWrite;
    logic [31:0] WB_ALU_res, WB_mdata;
    logic [4:0]  WB_wreg;
    logic        bus_err, misalign;

    int tests = 0;
    int fails = 0;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite), .MEM_Branch(MEM_Branch),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_zero(MEM_zero),
        .MEM_ALU_res(MEM_ALU_res), .MEM_rdata2(MEM_rdata2), .MEM_wreg(MEM_wreg),
        .MEM_PCSrc(MEM_PCSrc), .stall(stall), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .WB_MemtoReg(WB_MemtoReg), .WB_RegWrite(WB_RegWrite), .WB_ALU_res(WB_ALU_res),
        .WB_mdata(WB_mdata), .WB_wreg(WB_wreg), .bus_err(bus_err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        MEM_MemtoReg = 0; MEM_RegWrite = 0; MEM_Branch = 0;
        MEM_MemRead  = 0; MEM_MemWrite = 0; MEM_zero   = 0;
        MEM_ALU_res  = '0; MEM_rdata2  = '0; MEM_wreg  = '0;
    endtask

    // Runs one held memory op until its last ACCESS cycle (dm_req high, stall low); ack_at=0 never acks.
    task automatic run_access(input int ack_at, input logic [31:0] rdata,
                              output int req_n, output int stall_n, output int we_n,
                              output logic [31:0] addr_seen, output logic [31:0] wdata_seen,
                              output logic bubble_ok);
        bit done = 0;
        req_n = 0; stall_n = 0; we_n = 0; addr_seen = '0; wdata_seen = '0; bubble_ok = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            dm_ack = 1'b0;
            #1;
            if (dm_req) begin
                req_n++;
                addr_seen  = dm_addr;
                wdata_seen = dm_wdata;
                if (dm_we) we_n++;
                if (req_n == ack_at) begin
                    dm_ack   = 1'b1;
                    dm_rdata = rdata;
                end
            end
            #1;
            if (stall) stall_n++;
            if (dm_req && !stall) done = 1;
            @(posedge clk);
            #1;
            if (!done && (WB_RegWrite || WB_MemtoReg)) bubble_ok = 1'b0;
        end
        dm_ack = 1'b0;
        nop();
    endtask

    int          req_n, stall_n, we_n;
    logic [31:0] addr_seen, wdata_seen;
    logic        bubble_ok;

    initial begin
        rst_n = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
        nop();
        #12;
        check("rst_wb_regwrite", {31'd0, WB_RegWrite}, 0);
        check("rst_wb_alu",      WB_ALU_res, 0);
        check("rst_wb_mdata",    WB_mdata, 0);
        check("rst_bus_err",     {31'd0, bus_err}, 0);
        check("rst_misalign",    {31'd0, misalign}, 0);
        MEM_MemRead = 1'b1;
        #1;
        check("rst_stall_forced0", {31'd0, stall}, 0);
        check("rst_dm_req",        {31'd0, dm_req}, 0);
        nop();
        @(negedge clk);
        rst_n = 1'b1;

        // Non-memory pass-through
        MEM_RegWrite = 1'b1; MEM_ALU_res = 32'h0000_1234; MEM_wreg = 5'd5;
        #1;
        check("pass_stall", {31'd0, stall}, 0);
        step();
        check("pass_wb_alu",      WB_ALU_res, 32'h0000_1234);
        check("pass_wb_wreg",     {27'd0, WB_wreg}, 5);
        check("pass_wb_regwrite", {31'd0, WB_RegWrite}, 1);
        check("pass_wb_mdata",    WB_mdata, 0);

        // Branch resolution
        MEM_Branch = 1'b1; MEM_zero = 1'b1;
        #1;
        check("branch_taken", {31'd0, MEM_PCSrc}, 1);
        MEM_zero = 1'b0;
        #1;
        check("branch_not_taken", {31'd0, MEM_PCSrc}, 0);
        nop();
        step();

        // Load at 0x100, ack in 3rd ACCESS cycle
        MEM_MemRead = 1'b1; MEM_MemtoReg = 1'b1; MEM_RegWrite = 1'b1;
        MEM_ALU_res = 32'h0000_0100; MEM_wreg = 5'd7;
        run_access(3, 32'hDEAD_BEEF, req_n, stall_n, we_n, addr_seen, wdata_seen, bubble_ok);
        check("load_req_cycles",   req_n, 3);
        check("load_stall_cycles", stall_n, 3);
        check("load_addr",         addr_seen, 32'h0000_0100);
        check("load_bubbles",      {31'd0, bubble_ok}, 1);
        check("load_wb_mdata",     WB_mdata, 32'hDEAD_BEEF);
        check("load_wb_memtoreg",  {31'd0, WB_MemtoReg}, 1);
        check("load_wb_regwrite",  {31'd0, WB_RegWrite}, 1);
        check("load_wb_wreg",      {27'd0, WB_wreg}, 7);

        // Store at 0x40, ack in 1st ACCESS cycle
        MEM_MemWrite = 1'b1; MEM_ALU_res = 32'h0000_0040; MEM_rdata2 = 32'hA5A5_A5A5;
        run_access(1, 32'h1111_2222, req_n, stall_n, we_n, addr_seen, wdata_seen, bubble_ok);
        check("store_req_cycles",   req_n, 1);
        check("store_we_cycles",    we_n, 1);
        check("store_stall_cycles", stall_n, 1);
        check("store_addr",         addr_seen, 32'h0000_0040);
        check("store_wdata",        wdata_seen, 32'hA5A5_A5A5);
        check("store_wb_regwrite",  {31'd0, WB_RegWrite}, 0);
        check("store_bus_err",      {31'd0, bus_err}, 0);

        // Load that never acks: timeout
        MEM_MemRead = 1'b1; MEM_MemtoReg = 1'b1; MEM_RegWrite = 1'b1;
        MEM_ALU_res = 32'h0000_0200; MEM_wreg = 5'd9;
        run_access(0, 32'h0, req_n, stall_n, we_n, addr_seen, wdata_seen, bubble_ok);
        check("tmo_req_cycles",   req_n, 16);
        check("tmo_stall_cycles", stall_n, 16);
        check("tmo_bus_err",      {31'd0, bus_err}, 1);
        check("tmo_wb_regwrite",  {31'd0, WB_RegWrite}, 0);
        step();
        check("tmo_bus_err_pulse", {31'd0, bus_err}, 0);
        check("tmo_idle_req",      {31'd0, dm_req}, 0);

        // Reset asserted mid-ACCESS, instruction re-issued after release
        MEM_MemRead = 1'b1; MEM_MemtoReg = 1'b1; MEM_RegWrite = 1'b1;
        MEM_ALU_res = 32'h0000_0300; MEM_wreg = 5'd3;
        step();
        check("rstmid_req_before", {31'd0, dm_req}, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_req_drop",   {31'd0, dm_req}, 0);
        check("rstmid_stall",      {31'd0, stall}, 0);
        check("rstmid_wb_alu",     WB_ALU_res, 0);
        check("rstmid_wb_mdata",   WB_mdata, 0);
        check("rstmid_wb_ctrl",    {30'd0, WB_MemtoReg, WB_RegWrite}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rstmid_reissue_req", {31'd0, dm_req}, 1);
        dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
        #1;
        check("rstmid_ack_stall", {31'd0, stall}, 0);
        step();
        dm_ack = 1'b0;
        nop();
        check("rstmid_wb_mdata_after", WB_mdata, 32'h1234_5678);
        check("rstmid_wb_regwrite",    {31'd0, WB_RegWrite}, 1);

        // Misaligned load at 0x102
        MEM_MemRead = 1'b1; MEM_RegWrite = 1'b1; MEM_MemtoReg = 1'b1;
        MEM_ALU_res = 32'h0000_0102; MEM_wreg = 5'd4;
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        check("mis_stall", {31'd0, stall}, 0);
        check("mis_req",   {31'd0, dm_req}, 0);
        step();
        nop();
        check("mis_pulse",       {31'd0, misalign}, 1);
        check("mis_wb_regwrite", {31'd0, WB_RegWrite}, 0);
        check("mis_req_after",   {31'd0, dm_req}, 0);
        step();
        check("mis_pulse_end", {31'd0, misalign}, 0);
`else
        run_access(1, 32'hCAFE_F00D, req_n, stall_n, we_n, addr_seen, wdata_seen, bubble_ok);
        check("unal_req_cycles", req_n, 1);
        check("unal_addr",       addr_seen, 32'h0000_0100);
        check("unal_misalign",   {31'd0, misalign}, 0);
        check("unal_wb_mdata",   WB_mdata, 32'hCAFE_F00D);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
